geofence_ctrl: RTL and testbench

Frame-level controller for the geofence engine. It accepts one target point and six unordered fence vertices over a ready/valid input handshake. It then time-shares a single cross-product unit, first to sort the vertices angularly around vertex 0 and then to test the target against all six edges. It emits a one-cycle result strobe with the inside/outside flag, and it replaces the free-running, fixed-cadence input capture with back-pressure-capable sequencing.

---
 rtl/geofence_pkg.sv | 31 +++
 rtl/geofence_cross.sv | 41 ++++
 rtl/geofence_ctrl.sv | 172 +++++++++++++++++
 tb/tb_geofence_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/geofence_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : geofence_pkg
//  Description : Shared widths, step counts and state encoding for the
//                geofence controller and its cross-product unit.
//  Revision    : 1.0  initial release
// ============================================================================
package geofence_pkg;

    localparam int COORD_W    = 10;
    localparam int N_VERT     = 6;

    // Signed difference of two zero-extended coordinates, and the full
    // un-truncated cross product of two such difference vectors.
    localparam int DIFF_W     = COORD_W + 2;
    localparam int CROSS_W    = 2 * DIFF_W + 1;

    // Pairwise exchange sort over vertices 1..5 is C(5,2) compares;
    // the containment test visits every edge once.
    localparam int SORT_STEPS = 10;
    localparam int TEST_STEPS = 6;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SORT   = 2'd1,
        ST_TEST   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/geofence_cross.sv
`default_nettype none
// ============================================================================
//  Module      : geofence_cross
//  Description : Combinational 2-D cross product (a - o) x (b - o).
//                Coordinates are zero-extended, differenced as signed values
//                and multiplied at full width so sign and zero are exact.
//  Revision    : 1.0  initial release
// ============================================================================
module geofence_cross
    import geofence_pkg::*;
(
    input  logic [COORD_W-1:0]        i_ox,
    input  logic [COORD_W-1:0]        i_oy,
    input  logic [COORD_W-1:0]        i_ax,
    input  logic [COORD_W-1:0]        i_ay,
    input  logic [COORD_W-1:0]        i_bx,
    input  logic [COORD_W-1:0]        i_by,
    output logic signed [CROSS_W-1:0] o_cross
);

    logic signed [DIFF_W-1:0]  w_dax, w_day, w_dbx, w_dby;
    logic signed [CROSS_W-1:0] w_dax_e, w_day_e, w_dbx_e, w_dby_e;
    logic signed [CROSS_W-1:0] w_p1, w_p2;

    assign w_dax = $signed({2'b00, i_ax}) - $signed({2'b00, i_ox});
    assign w_day = $signed({2'b00, i_ay}) - $signed({2'b00, i_oy});
    assign w_dbx = $signed({2'b00, i_bx}) - $signed({2'b00, i_ox});
    assign w_dby = $signed({2'b00, i_by}) - $signed({2'b00, i_oy});

    // Sign-extend before multiplying so the product keeps every bit.
    assign w_dax_e = $signed({{(CROSS_W-DIFF_W){w_dax[DIFF_W-1]}}, w_dax});
    assign w_day_e = $signed({{(CROSS_W-DIFF_W){w_day[DIFF_W-1]}}, w_day});
    assign w_dbx_e = $signed({{(CROSS_W-DIFF_W){w_dbx[DIFF_W-1]}}, w_dbx});
    assign w_dby_e = $signed({{(CROSS_W-DIFF_W){w_dby[DIFF_W-1]}}, w_dby});

    assign w_p1    = w_dax_e * w_dby_e;
    assign w_p2    = w_day_e * w_dbx_e;
    assign o_cross = w_p1 - w_p2;

endmodule
`default_nettype wire

// File: rtl/geofence_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : geofence_ctrl
//  Description : Loads a target and six fence vertices over ready/valid,
//                sorts the vertices angularly around vertex 0, then tests the
//                target against every edge, all through one shared
//                cross-product unit. Emits a one-cycle result strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module geofence_ctrl
    import geofence_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               valid,
    output logic               is_inside
);

    state_t             r_state;
    logic [2:0]         r_cnt;
    logic [2:0]         r_i;
    logic [2:0]         r_j;
    logic [3:0]         r_step;
    logic [COORD_W-1:0] r_tx;
    logic [COORD_W-1:0] r_ty;
    logic [COORD_W-1:0] r_vx [N_VERT];
    logic [COORD_W-1:0] r_vy [N_VERT];
    logic               r_flag;
    logic               r_valid;
    logic               r_inside;

    logic [2:0]         w_load_idx;
    logic [2:0]         w_k;
    logic [2:0]         w_kn;
    logic [COORD_W-1:0] w_ox, w_oy, w_ax, w_ay, w_bx, w_by;
    logic signed [CROSS_W-1:0] w_cross;
    logic               w_nonneg;
    logic               w_neg;

    assign w_load_idx = r_cnt - 3'd1;
    assign w_k        = r_step[2:0];
    assign w_kn       = (w_k == 3'(N_VERT - 1)) ? 3'd0 : w_k + 3'd1;

    // Operand mux for the shared cross unit. In TEST the edge cross
    // (Vk-T)x(Vk+1-Vk) equals (Vk-T)x(Vk+1-T), so both phases use the
    // same origin/a/b form: origin V0 while sorting, origin T while testing.
    always_comb begin
        w_ox = r_tx;
        w_oy = r_ty;
        w_ax = r_vx[w_k];
        w_ay = r_vy[w_k];
        w_bx = r_vx[w_kn];
        w_by = r_vy[w_kn];
        if (r_state == ST_SORT) begin
            w_ox = r_vx[0];
            w_oy = r_vy[0];
            w_ax = r_vx[r_i];
            w_ay = r_vy[r_i];
            w_bx = r_vx[r_j];
            w_by = r_vy[r_j];
        end
    end

    geofence_cross u_cross (
        .i_ox    (w_ox),
        .i_oy    (w_oy),
        .i_ax    (w_ax),
        .i_ay    (w_ay),
        .i_bx    (w_bx),
        .i_by    (w_by),
        .o_cross (w_cross)
    );

    assign w_nonneg = (w_cross >= 0);
    assign w_neg    = (w_cross < 0);

    // Frame sequencer: load, compare-swap sort, edge test, result strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_LOAD;
            r_cnt    <= 3'd0;
            r_i      <= 3'd1;
            r_j      <= 3'd2;
            r_step   <= 4'd0;
            r_tx     <= '0;
            r_ty     <= '0;
            r_flag   <= 1'b1;
            r_valid  <= 1'b0;
            r_inside <= 1'b0;
            for (int n = 0; n < N_VERT; n++) begin
                r_vx[n] <= '0;
                r_vy[n] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (r_cnt == 3'd0) begin
                            r_tx <= X;
                            r_ty <= Y;
                        end else begin
                            r_vx[w_load_idx] <= X;
                            r_vy[w_load_idx] <= Y;
                        end
                        if (r_cnt == 3'(N_VERT)) begin
                            r_cnt   <= 3'd0;
                            r_i     <= 3'd1;
                            r_j     <= 3'd2;
                            r_step  <= 4'd0;
                            r_state <= ST_SORT;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                ST_SORT: begin
                    // Non-negative cross means Vj is not clockwise of Vi.
                    if (w_nonneg) begin
                        r_vx[r_i] <= r_vx[r_j];
                        r_vy[r_i] <= r_vy[r_j];
                        r_vx[r_j] <= r_vx[r_i];
                        r_vy[r_j] <= r_vy[r_i];
                    end
                    if (r_step == 4'(SORT_STEPS - 1)) begin
                        r_step  <= 4'd0;
                        r_i     <= 3'd1;
                        r_j     <= 3'd2;
                        r_flag  <= 1'b1;
                        r_state <= ST_TEST;
                    end else begin
                        r_step <= r_step + 4'd1;
                        if (r_j == 3'(N_VERT - 1)) begin
                            r_i <= r_i + 3'd1;
                            r_j <= r_i + 3'd2;
                        end else begin
                            r_j <= r_j + 3'd1;
                        end
                    end
                end
                ST_TEST: begin
                    // Zero cross (target on an edge line) is treated as outside.
                    r_flag <= r_flag & w_neg;
                    if (r_step == 4'(TEST_STEPS - 1)) begin
                        r_step   <= 4'd0;
                        r_valid  <= 1'b1;
                        r_inside <= r_flag & w_neg;
                        r_state  <= ST_RESULT;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                ST_RESULT: begin
                    r_state <= ST_LOAD;
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_LOAD) && !reset;
    assign valid     = r_valid;
    assign is_inside = r_inside;

endmodule
`default_nettype wire

// File: tb/tb_geofence_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_geofence_ctrl
//  Description : Self-checking bench for geofence_ctrl: directed vector table,
//                stall/back-to-back/reset sequences, and randomized frames
//                against a reference model of the fence rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_geofence_ctrl;

    localparam int CW = 10;

    typedef struct packed {
        logic [CW-1:0]        tx;
        logic [CW-1:0]        ty;
        logic [5:0][CW-1:0]   vx;
        logic [5:0][CW-1:0]   vy;
        logic                 exp;
    } vec_t;

    logic          clk;
    logic          reset;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;
    logic          in_valid;
    logic          in_ready;
    logic          valid;
    logic          is_inside;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  last_inside;
    int  t_res;
    int  t_prev;

    geofence_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .X         (X),
        .Y         (Y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .valid     (valid),
        .is_inside (is_inside)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not end, got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic vec_t mk(input int tx, input int ty,
                                input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2, input int x3, input int y3,
                                input int x4, input int y4, input int x5, input int y5,
                                input bit e);
        vec_t f;
        f.tx = CW'(tx);  f.ty = CW'(ty);
        f.vx[0] = CW'(x0); f.vy[0] = CW'(y0);
        f.vx[1] = CW'(x1); f.vy[1] = CW'(y1);
        f.vx[2] = CW'(x2); f.vy[2] = CW'(y2);
        f.vx[3] = CW'(x3); f.vy[3] = CW'(y3);
        f.vx[4] = CW'(x4); f.vy[4] = CW'(y4);
        f.vx[5] = CW'(x5); f.vy[5] = CW'(y5);
        f.exp = e;
        return f;
    endfunction

    // Reference: angular compare-swap sort around vertex 0, then the target
    // must lie strictly on the negative side of every edge.
    function automatic bit model_inside(input vec_t f);
        int vx[6];
        int vy[6];
        int tx, ty, c, e, n, s;
        bit r;
        tx = int'(f.tx);
        ty = int'(f.ty);
        for (int i = 0; i < 6; i++) begin
            vx[i] = int'(f.vx[i]);
            vy[i] = int'(f.vy[i]);
        end
        for (int i = 1; i < 5; i++) begin
            for (int j = i + 1; j < 6; j++) begin
                c = (vx[i] - vx[0]) * (vy[j] - vy[0]) - (vy[i] - vy[0]) * (vx[j] - vx[0]);
                if (c >= 0) begin
                    s = vx[i]; vx[i] = vx[j]; vx[j] = s;
                    s = vy[i]; vy[i] = vy[j]; vy[j] = s;
                end
            end
        end
        r = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = (k + 1) % 6;
            e = (vx[k] - tx) * (vy[n] - vy[k]) - (vy[k] - ty) * (vx[n] - vx[k]);
            if (!(e < 0)) r = 1'b0;
        end
        return r;
    endfunction

    function automatic vec_t rand_frame();
        vec_t f;
        int ox[6];
        int oy[6];
        int perm[6];
        int cx, cy, h, j, t, mode;
        ox = '{2, 1, -1, -2, -1, 1};
        oy = '{0, 2, 2, 0, -2, -2};
        cx = int'($urandom_range(300, 700));
        cy = int'($urandom_range(300, 700));
        h  = 2 * int'($urandom_range(5, 62));
        for (int i = 0; i < 6; i++) perm[i] = i;
        for (int i = 5; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        mode = int'($urandom_range(0, 7));
        for (int i = 0; i < 6; i++) begin
            if (mode == 7) begin
                f.vx[i] = CW'($urandom_range(0, 1023));
                f.vy[i] = CW'($urandom_range(0, 1023));
            end else begin
                f.vx[i] = CW'(cx + ox[perm[i]] * h);
                f.vy[i] = CW'(cy + oy[perm[i]] * h);
            end
        end
        if (mode == 0) begin
            f.tx = CW'(cx + 2 * h);
            f.ty = CW'(cy);
        end else if (mode == 1) begin
            f.tx = CW'(cx + (3 * h) / 2);
            f.ty = CW'(cy + h);
        end else begin
            f.tx = CW'(cx + int'($urandom_range(0, 4 * h + 40)) - 2 * h - 20);
            f.ty = CW'(cy + int'($urandom_range(0, 4 * h + 40)) - 2 * h - 20);
        end
        f.exp = model_inside(f);
        return f;
    endfunction

    // Presents target then six vertices; starts and ends in the low clock phase.
    task automatic send_points(input vec_t f, input int maxgap, input bit keep_high);
        logic [CW-1:0] px[7];
        logic [CW-1:0] py[7];
        int gap, waited;
        px[0] = f.tx; py[0] = f.ty;
        for (int i = 0; i < 6; i++) begin
            px[i + 1] = f.vx[i];
            py[i + 1] = f.vy[i];
        end
        for (int p = 0; p < 7; p++) begin
            gap = (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0;
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                X = CW'($urandom);
                Y = CW'($urandom);
                @(posedge clk); @(negedge clk);
            end
            X = px[p];
            Y = py[p];
            in_valid = 1'b1;
            waited = 0;
            while (!in_ready && waited < 100) begin
                @(posedge clk); @(negedge clk);
                waited++;
            end
            if (!in_ready) check("accept_timeout", 0, 1);
            @(posedge clk); @(negedge clk);
        end
        in_valid = keep_high;
        X = CW'($urandom);
        Y = CW'($urandom);
    endtask

    // Called in cycle A+1; checks the busy window, the strobe at A+17 and
    // in_ready returning at A+18.
    task automatic check_result(input string name, input bit want);
        int busy_bad;
        busy_bad = 0;
        for (int m = 0; m < 16; m++) begin
            if (m > 0) @(negedge clk);
            if (valid !== 1'b0 || in_ready !== 1'b0 || is_inside !== last_inside) busy_bad++;
            X = CW'($urandom);
            Y = CW'($urandom);
        end
        check({name, "_busy_window_bad_cycles"}, busy_bad, 0);
        @(negedge clk);
        t_res = cyc;
        check({name, "_valid_at_17"}, int'(valid), 1);
        check({name, "_ready_at_17"}, int'(in_ready), 0);
        check({name, "_is_inside"}, int'(is_inside), int'(want));
        last_inside = want;
        @(negedge clk);
        check({name, "_ready_back_valid_low"}, int'({in_ready, valid}), 2);
    endtask

    vec_t tbl[8];

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        X = '0;
        Y = '0;
        last_inside = 1'b0;
        t_res = 0;
        t_prev = 0;

        tbl[0] = mk(500, 300, 400,100, 600,100, 700,300, 600,500, 400,500, 300,300, 1'b1);
        tbl[1] = mk(500, 300, 300,300, 600,500, 400,100, 700,300, 400,500, 600,100, 1'b1);
        tbl[2] = mk( 50,  50, 400,100, 600,100, 700,300, 600,500, 400,500, 300,300, 1'b0);
        tbl[3] = mk(500, 100, 400,100, 600,100, 700,300, 600,500, 400,500, 300,300, 1'b0);
        tbl[4] = mk(400, 100, 300,300, 600,500, 400,100, 700,300, 400,500, 600,100, 1'b0);
        tbl[5] = mk(500, 500, 500,500, 500,500, 500,500, 500,500, 500,500, 500,500, 1'b0);
        tbl[6] = mk(690, 300, 600,500, 300,300, 700,300, 400,100, 600,100, 400,500, 1'b1);
        tbl[7] = mk(710, 300, 600,500, 300,300, 700,300, 400,100, 600,100, 400,500, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_is_inside", int'(is_inside), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release_in_ready", int'(in_ready), 1);

        // Directed table without stalls, then with 1..5-cycle gaps
        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 0; v < 8; v++) begin
                send_points(tbl[v], pass * 5, 1'b0);
                check_result($sformatf("tbl%0d_pass%0d", v, pass), tbl[v].exp);
            end
        end

        // Back-to-back frames: seven load cycles plus seventeen busy cycles
        for (int b = 0; b < 3; b++) begin
            send_points(tbl[(b == 1) ? 2 : b], 0, 1'b1);
            check_result($sformatf("b2b%0d", b), tbl[(b == 1) ? 2 : b].exp);
            if (b > 0) check($sformatf("b2b%0d_strobe_period", b), t_res - t_prev, 24);
            t_prev = t_res;
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Reset during sort step 4 of an inside frame
        send_points(tbl[0], 0, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_is_inside", int'(is_inside), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_inside = 1'b0;
        #1;
        check("midrst_release_ready", int'(in_ready), 1);
        begin
            int stray;
            stray = 0;
            for (int m = 0; m < 25; m++) begin
                @(negedge clk);
                if (valid !== 1'b0 || in_ready !== 1'b1) stray++;
            end
            check("midrst_no_valid_idle", stray, 0);
        end
        send_points(tbl[2], 0, 1'b0);
        check_result("midrst_new_frame", 1'b0);

        // Randomized frames against the reference model
        for (int r = 0; r < 40; r++) begin
            vec_t f;
            f = rand_frame();
            send_points(f, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            check_result($sformatf("rand%0d", r), f.exp);
        end

        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
